// File: rtl/demux1x7_capture_if.sv
// Bus between the 7:1 mux receive path and the demux1x7_capture block.
// Parity ports exist only when DEMUX_PARITY_EN is defined.
interface demux1x7_capture_if;
    logic       d;
    logic       d_valid;
    logic [2:0] s;
    logic       auto_en;
    logic       clr;
    logic [6:0] o;
    logic [2:0] cur_sel;
    logic       frame_done;
    logic       sel_err;
`ifdef DEMUX_PARITY_EN
    logic       par_chk;
    logic       par;
    logic       par_err;

    modport master (
        output d, d_valid, s, auto_en, clr, par_chk,
        input  o, cur_sel, frame_done, sel_err, par, par_err
    );
    modport slave (
        input  d, d_valid, s, auto_en, clr, par_chk,
        output o, cur_sel, frame_done, sel_err, par, par_err
    );
`else
    modport master (
        output d, d_valid, s, auto_en, clr,
        input  o, cur_sel, frame_done, sel_err
    );
    modport slave (
        input  d, d_valid, s, auto_en, clr,
        output o, cur_sel, frame_done, sel_err
    );
`endif
endinterface

// File: rtl/demux1x7_capture.sv
// Registered 1:7 demux / deserializer with manual (select) and auto (counter) capture.
// Optional even-parity check of each completed auto frame under DEMUX_PARITY_EN.
module demux1x7_capture #(
    parameter logic [6:0] RST_VAL = 7'b0000000
) (
    input  logic               clk,
    input  logic               rst_n,
    demux1x7_capture_if.slave  bus
);
    localparam int unsigned N_OUT = 7;
    localparam int unsigned SEL_W = 3;
    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(N_OUT - 1);
    localparam logic [SEL_W-1:0] BAD_SEL   = SEL_W'(N_OUT);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t             state_q, state_n;
    logic [N_OUT-1:0]   o_q, o_n;
    logic [SEL_W-1:0]   sel_q, sel_n;
    logic               fd_q, fd_n;
    logic               se_q, se_n;
    logic               par_q, par_n;
    logic               pe_q, pe_n;
    logic               word_par_c;
    logic               par_chk_c;

`ifdef DEMUX_PARITY_EN
    assign par_chk_c = bus.par_chk;
`else
    assign par_chk_c = 1'b0;
`endif
    // Parity of the word as it will stand once lane 6 takes the current bit.
    assign word_par_c = ^{bus.d, o_q[N_OUT-2:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            o_q     <= RST_VAL;
            sel_q   <= '0;
            fd_q    <= 1'b0;
            se_q    <= 1'b0;
            par_q   <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            o_q     <= o_n;
            sel_q   <= sel_n;
            fd_q    <= fd_n;
            se_q    <= se_n;
            par_q   <= par_n;
            pe_q    <= pe_n;
        end
    end

    always_comb begin
        state_n = state_q;
        o_n     = o_q;
        sel_n   = sel_q;
        fd_n    = 1'b0;
        se_n    = 1'b0;
        par_n   = par_q;
        pe_n    = 1'b0;
        if (bus.clr) begin
            state_n = IDLE;
            o_n     = RST_VAL;
            sel_n   = '0;
            par_n   = 1'b0;
        end else if (!bus.auto_en) begin
            // Manual mode: any partial auto frame is abandoned, written lanes kept.
            state_n = IDLE;
            sel_n   = '0;
            if (bus.d_valid) begin
                if (bus.s != BAD_SEL) o_n[bus.s] = bus.d;
                else                  se_n = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.d_valid) begin
                        o_n[0]  = bus.d;
                        sel_n   = SEL_W'(1);
                        state_n = FILL;
                    end else begin
                        sel_n   = '0;
                        state_n = IDLE;
                    end
                end
                FILL: begin
                    if (bus.d_valid) begin
                        o_n[sel_q] = bus.d;
                        if (sel_q == LAST_LANE) begin
                            sel_n   = '0;
                            fd_n    = 1'b1;
                            state_n = DONE;
                            par_n   = word_par_c;
                            pe_n    = word_par_c ^ par_chk_c;
                        end else begin
                            sel_n   = sel_q + SEL_W'(1);
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    sel_n   = '0;
                end
            endcase
        end
    end

    assign bus.o          = o_q;
    assign bus.cur_sel    = sel_q;
    assign bus.frame_done = fd_q;
    assign bus.sel_err    = se_q;
`ifdef DEMUX_PARITY_EN
    assign bus.par        = par_q;
    assign bus.par_err    = pe_q;
`else
    logic unused_c;
    assign unused_c = par_q ^ pe_q;
`endif
endmodule

// File: tb/tb_demux1x7_capture.sv
// Randomized + directed bench for demux1x7_capture against a lane/position model.
module tb_demux1x7_capture;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    demux1x7_capture_if bus();
    demux1x7_capture dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    // Model: word bits, number of bits already captured in the current auto frame.
    logic [6:0] m_o;
    int         m_pos;
    logic       m_fd, m_se, m_par, m_pe;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic r, cl, ae, dv, dd, input logic [2:0] ss, input logic pc);
        m_fd = 1'b0; m_se = 1'b0; m_pe = 1'b0;
        if (!r || cl) begin
            m_o = 7'd0; m_pos = 0; m_par = 1'b0;
        end else if (!ae) begin
            m_pos = 0;
            if (dv) begin
                if (int'(ss) < 7) m_o[ss] = dd;
                else              m_se = 1'b1;
            end
        end else if (dv) begin
            m_o[m_pos] = dd;
            if (m_pos == 6) begin
                int ones = 0;
                for (int i = 0; i < 7; i++) ones += int'(m_o[i]);
                m_fd  = 1'b1;
                m_par = 1'(ones % 2);
                m_pe  = (m_par != pc);
            end
            m_pos = (m_pos + 1) % 7;
        end
    endtask

    task automatic step(input logic r, cl, ae, dv, dd, input logic [2:0] ss, input logic pc);
        rst_n = r; bus.clr = cl; bus.auto_en = ae; bus.d_valid = dv; bus.d = dd; bus.s = ss;
`ifdef DEMUX_PARITY_EN
        bus.par_chk = pc;
`endif
        @(posedge clk);
        model(r, cl, ae, dv, dd, ss, pc);
        @(negedge clk);
        check_eq("o", 32'(bus.o), 32'(m_o));
        check_eq("cur_sel", 32'(bus.cur_sel), 32'(m_pos));
        check_eq("frame_done", 32'(bus.frame_done), 32'(m_fd));
        check_eq("sel_err", 32'(bus.sel_err), 32'(m_se));
`ifdef DEMUX_PARITY_EN
        check_eq("par", 32'(bus.par), 32'(m_par));
        check_eq("par_err", 32'(bus.par_err), 32'(m_pe));
`endif
    endtask

    task automatic send_word(input logic [6:0] w, input int gap, input logic pc);
        for (int i = 0; i < 7; i++) begin
            for (int g = 0; g < gap; g++) step(1, 0, 1, 0, 0, 3'd0, 0);
            step(1, 0, 1, 1, w[i], 3'd0, pc);
        end
    endtask

    initial begin
        int fd_seen;
        logic ae;
        ae = 1'b1;
        m_o = 7'd0; m_pos = 0; m_fd = 0; m_se = 0; m_par = 0; m_pe = 0;
        @(negedge clk);
        step(0, 0, 0, 0, 0, 3'd0, 0);
        step(0, 0, 0, 0, 0, 3'd0, 0);
        check_eq("reset_o", 32'(bus.o), 32'h0);

        // Continuous auto frame, then frame_done must drop and cur_sel sit at 0.
        send_word(7'b1010101, 0, 1);
        check_eq("auto_word", 32'(bus.o), 32'h55);
        check_eq("auto_fd", 32'(bus.frame_done), 32'h1);
        step(1, 0, 1, 0, 0, 3'd0, 0);
        check_eq("auto_fd_drop", 32'(bus.frame_done), 32'h0);
`ifdef DEMUX_PARITY_EN
        check_eq("par_value", 32'(bus.par), 32'h0);
`endif

        // Gapped frame.
        step(1, 1, 1, 0, 0, 3'd0, 0);
        send_word(7'b1010101, 2, 0);
        check_eq("gap_word", 32'(bus.o), 32'h55);

        // Back-to-back frames: count frame_done pulses.
        fd_seen = 0;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 7; i++) begin
                step(1, 0, 1, 1, (f == 0), 3'd0, 0);
                fd_seen += int'(bus.frame_done);
            end
        check_eq("b2b_pulses", 32'(fd_seen), 32'd2);
        check_eq("b2b_word", 32'(bus.o), 32'h0);

        // Manual capture and illegal select.
        step(1, 0, 0, 1, 1, 3'd3, 0);
        check_eq("manual_s3", 32'(bus.o), 32'h08);
        step(1, 0, 0, 1, 1, 3'd7, 0);
        check_eq("manual_s7_o", 32'(bus.o), 32'h08);
        check_eq("manual_s7_err", 32'(bus.sel_err), 32'h1);

        // Reset mid-frame, then a clean frame.
        for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 1, 3'd0, 0);
        step(0, 0, 1, 1, 1, 3'd0, 0);
        check_eq("midrst_o", 32'(bus.o), 32'h0);
        check_eq("midrst_sel", 32'(bus.cur_sel), 32'h0);
        send_word(7'b0110011, 0, 0);
        check_eq("midrst_word", 32'(bus.o), 32'h33);

        // clr together with d_valid during FILL drops the bit.
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 1, 3'd0, 0);
        step(1, 1, 1, 1, 1, 3'd0, 0);
        check_eq("clr_o", 32'(bus.o), 32'h0);
        check_eq("clr_sel", 32'(bus.cur_sel), 32'h0);

        // Randomized traffic, including mode flips mid-frame.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) ae = ~ae;
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 39) == 0), ae,
                 ($urandom_range(0, 9) < 7), 1'($urandom), 3'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
